// File: rtl/seven_segment_if.sv
// seven_segment_if
//   Bundles the scanner's display-side signals so the producer and the
//   scanner share one port.
//
//   Signal summary:
//     enable         scanning enabled when 1
//     display0..5    7-bit active-low segment patterns for digits 0..5
//     blank_mask     bit i = 1 keeps digit i dark during its slot
//     seg_out        shared active-low segment bus
//     digit_sel      active-low anode selects, at most one bit low
//     frame_tick     one-cycle pulse in the final show cycle of digit 5
//     dbg_state      scanner FSM state (0 = IDLE, 1 = BLANK, 2 = SHOW)
//
//   Handshake: none. Every input is a level sampled on the rising clock
//   edge, and every output is a registered level. There is no valid/ready
//   pair. Display patterns and blank_mask are captured only when a frame
//   starts, so the producer may change them at any time.
interface seven_segment_if;
  logic       enable;
  logic [6:0] display0;
  logic [6:0] display1;
  logic [6:0] display2;
  logic [6:0] display3;
  logic [6:0] display4;
  logic [6:0] display5;
  logic [5:0] blank_mask;
  logic [6:0] seg_out;
  logic [5:0] digit_sel;
  logic       frame_tick;
  logic [1:0] dbg_state;

  modport master (
    output enable, display0, display1, display2, display3, display4,
           display5, blank_mask,
    input  seg_out, digit_sel, frame_tick, dbg_state
  );

  modport slave (
    input  enable, display0, display1, display2, display3, display4,
           display5, blank_mask,
    output seg_out, digit_sel, frame_tick, dbg_state
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
//   Time-multiplexed driver for a six-digit common-anode 7-segment display.
//   The scanner shows one digit at a time and rotates through digits 0..5.
//   Each digit slot lasts REFRESH_DIV cycles. The first BLANK_CYCLES cycles
//   of a slot are blank (all anodes off) to suppress ghosting. The digit is
//   shown for the rest of the slot. The display patterns and blank_mask are
//   captured at the start of every frame, so a frame never mixes old and
//   new data.
//
//   Ports:
//     clk    rising-edge system clock
//     rst_n  asynchronous active-low reset
//     bus    seven_segment_if.slave (enable, display0..5, blank_mask in;
//            seg_out, digit_sel, frame_tick, dbg_state out)
module seven_segment_scanner #(
  parameter int         NUM_DIGITS   = 6,
  parameter int         REFRESH_DIV  = 50000,
  parameter int         BLANK_CYCLES = 16,
  parameter logic [6:0] SEG_OFF      = 7'b1111111
) (
  input  logic             clk,
  input  logic             rst_n,
  seven_segment_if.slave   bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0][6:0]  snap_q, snap_d;
  logic [5:0]       mask_q, mask_d;
  logic [6:0]       seg_out_q, seg_out_d;
  logic [5:0]       digit_sel_q, digit_sel_d;
  logic             frame_tick_q, frame_tick_d;
  logic             load_snap;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    snap_d    = snap_q;
    mask_d    = mask_q;
    load_snap = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d   = BLANK;
          idx_d     = '0;
          cnt_d     = '0;
          load_snap = 1'b1;
        end
      end
      BLANK: begin
        // cnt runs across the whole slot; the show phase starts at
        // cnt = BLANK_CYCLES.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (cnt_q == SLOT_LAST) begin
          cnt_d   = '0;
          state_d = BLANK;
          if (idx_q == IDX_LAST) begin
            idx_d     = '0;
            load_snap = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    // Dropping enable wins in every state. Scanning never resumes mid-frame.
    if (!bus.enable) begin
      state_d   = IDLE;
      idx_d     = '0;
      cnt_d     = '0;
      load_snap = 1'b0;
    end

    if (load_snap) begin
      snap_d = {bus.display5, bus.display4, bus.display3,
                bus.display2, bus.display1, bus.display0};
      mask_d = bus.blank_mask;
    end

    // The outputs are registered from the next-state values, so they line
    // up with the state during the same cycle.
    seg_out_d    = SEG_OFF;
    digit_sel_d  = '1;
    frame_tick_d = 1'b0;
    if (state_d == SHOW) begin
      if (!mask_d[idx_d]) begin
        digit_sel_d[idx_d] = 1'b0;
        seg_out_d          = snap_d[idx_d];
      end
      frame_tick_d = (idx_d == IDX_LAST) && (cnt_d == SLOT_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      snap_q       <= {6{SEG_OFF}};
      mask_q       <= '0;
      seg_out_q    <= SEG_OFF;
      digit_sel_q  <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      snap_q       <= snap_d;
      mask_q       <= mask_d;
      seg_out_q    <= seg_out_d;
      digit_sel_q  <= digit_sel_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.seg_out    = seg_out_q;
  assign bus.digit_sel  = digit_sel_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner
//   Bench for seven_segment_scanner using REFRESH_DIV=8, BLANK_CYCLES=2.
//   Cycle k is the interval after the k-th rising edge that samples
//   enable=1 from IDLE. Expected {frame_tick, digit_sel, seg_out} words
//   come from a slot-timing model and are queued before the edges are run.
module tb_seven_segment_scanner;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int ND = 6;
  localparam logic [13:0] OFF_W = {1'b0, 6'h3F, 7'h7F};

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n  = 1'b1;

  seven_segment_if bus();

  seven_segment_scanner #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC),
    .SEG_OFF     (7'h7F)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [13:0]     exp_q[$];
  logic [13:0]     obs_w, exp_w;
  int              n_checks = 0;
  int              n_pass   = 0;
  logic [5:0][6:0] disp;
  logic [5:0]      mask;

  localparam logic [5:0][6:0] BASE_DISP =
    {7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};

  // Expected outputs for cycle c of a frame sequence that uses d and m.
  function automatic logic [13:0] model(int c, logic [5:0][6:0] d, logic [5:0] m);
    int         slot;
    int         pos;
    logic       ft;
    logic [5:0] sel;
    slot = (c / RD) % ND;
    pos  = c % RD;
    ft   = (slot == ND - 1) && (pos == RD - 1);
    sel  = 6'h3F;
    if (pos >= BC && !m[slot]) begin
      sel[slot] = 1'b0;
      return {ft, sel, d[slot]};
    end
    return {ft, 6'h3F, 7'h7F};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_inputs();
    bus.display0   = disp[0];
    bus.display1   = disp[1];
    bus.display2   = disp[2];
    bus.display3   = disp[3];
    bus.display4   = disp[4];
    bus.display5   = disp[5];
    bus.blank_mask = mask;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stop_scan();
    bus.enable = 1'b0;
    tick();
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.enable = 1'b0;
    disp = BASE_DISP;
    mask = '0;
    drive_inputs();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.seg_out !== 7'h7F) $display("FAIL reset_seg got=%h exp=7f", bus.seg_out);
    else n_pass++;
    n_checks++;
    if (bus.digit_sel !== 6'h3F) $display("FAIL reset_sel got=%b exp=111111", bus.digit_sel);
    else n_pass++;
    n_checks++;
    if (bus.frame_tick !== 1'b0) $display("FAIL reset_tick got=%b exp=0", bus.frame_tick);
    else n_pass++;
    n_checks++;
    if (bus.dbg_state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", bus.dbg_state);
    else n_pass++;
    clk_en = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(OFF_W);
    for (int i = 0; i < 6; i++) begin
      tick();
      obs_w = {bus.frame_tick, bus.digit_sel, bus.seg_out};
      exp_w = exp_q.pop_front();
      n_checks++;
      if (obs_w !== exp_w) $display("FAIL reset_idle c=%0d got=%h exp=%h", i, obs_w, exp_w);
      else n_pass++;
    end
  endtask

  task automatic test_scan_order();
    disp = BASE_DISP;
    mask = '0;
    drive_inputs();
    for (int c = 0; c < 50; c++) exp_q.push_back(model(c, disp, mask));
    bus.enable = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      obs_w = {bus.frame_tick, bus.digit_sel, bus.seg_out};
      exp_w = exp_q.pop_front();
      n_checks++;
      if (obs_w !== exp_w) $display("FAIL scan c=%0d got=%h exp=%h", c, obs_w, exp_w);
      else n_pass++;
      n_checks++;
      if ($countones(~bus.digit_sel) > 1) $display("FAIL scan_onehot c=%0d got=%b exp=<=1 low", c, bus.digit_sel);
      else n_pass++;
    end
    stop_scan();
  endtask

  task automatic test_snapshot();
    logic [5:0][6:0] d2;
    disp = BASE_DISP;
    mask = '0;
    drive_inputs();
    d2 = disp;
    d2[3] = 7'h00;
    for (int c = 0; c < 48; c++) exp_q.push_back(model(c, disp, mask));
    for (int c = 48; c < 96; c++) exp_q.push_back(model(c, d2, mask));
    bus.enable = 1'b1;
    for (int c = 0; c < 96; c++) begin
      tick();
      obs_w = {bus.frame_tick, bus.digit_sel, bus.seg_out};
      exp_w = exp_q.pop_front();
      n_checks++;
      if (obs_w !== exp_w) $display("FAIL snapshot c=%0d got=%h exp=%h", c, obs_w, exp_w);
      else n_pass++;
      if (c == 20) begin
        disp = d2;
        drive_inputs();
      end
    end
    stop_scan();
  endtask

  task automatic test_mask();
    disp = BASE_DISP;
    mask = 6'b000100;
    drive_inputs();
    for (int c = 0; c < 50; c++) exp_q.push_back(model(c, disp, mask));
    bus.enable = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      obs_w = {bus.frame_tick, bus.digit_sel, bus.seg_out};
      exp_w = exp_q.pop_front();
      n_checks++;
      if (obs_w !== exp_w) $display("FAIL mask c=%0d got=%h exp=%h", c, obs_w, exp_w);
      else n_pass++;
    end
    stop_scan();
  endtask

  task automatic test_enable_drop();
    disp = BASE_DISP;
    mask = '0;
    drive_inputs();
    for (int c = 0; c < 14; c++) exp_q.push_back(model(c, disp, mask));
    for (int c = 14; c < 60; c++) exp_q.push_back(OFF_W);
    bus.enable = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick();
      obs_w = {bus.frame_tick, bus.digit_sel, bus.seg_out};
      exp_w = exp_q.pop_front();
      n_checks++;
      if (obs_w !== exp_w) $display("FAIL en_drop c=%0d got=%h exp=%h", c, obs_w, exp_w);
      else n_pass++;
      if (c == 13) bus.enable = 1'b0;
    end
    n_checks++;
    if (bus.dbg_state !== 2'd0) $display("FAIL en_drop_state got=%0d exp=0", bus.dbg_state);
    else n_pass++;
    disp[0] = 7'h08;
    drive_inputs();
    for (int c = 0; c < 12; c++) exp_q.push_back(model(c, disp, mask));
    bus.enable = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      obs_w = {bus.frame_tick, bus.digit_sel, bus.seg_out};
      exp_w = exp_q.pop_front();
      n_checks++;
      if (obs_w !== exp_w) $display("FAIL en_restart c=%0d got=%h exp=%h", c, obs_w, exp_w);
      else n_pass++;
    end
    stop_scan();
  endtask

  task automatic test_mid_show_reset();
    disp = BASE_DISP;
    mask = '0;
    drive_inputs();
    for (int c = 0; c < 5; c++) exp_q.push_back(model(c, disp, mask));
    bus.enable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      obs_w = {bus.frame_tick, bus.digit_sel, bus.seg_out};
      exp_w = exp_q.pop_front();
      n_checks++;
      if (obs_w !== exp_w) $display("FAIL pre_rst c=%0d got=%h exp=%h", c, obs_w, exp_w);
      else n_pass++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.digit_sel !== 6'h3F) $display("FAIL rst_async_sel got=%b exp=111111", bus.digit_sel);
    else n_pass++;
    n_checks++;
    if (bus.seg_out !== 7'h7F) $display("FAIL rst_async_seg got=%h exp=7f", bus.seg_out);
    else n_pass++;
    n_checks++;
    if (bus.dbg_state !== 2'd0) $display("FAIL rst_async_state got=%0d exp=0", bus.dbg_state);
    else n_pass++;
    #2 rst_n = 1'b1;
    for (int c = 0; c < 50; c++) exp_q.push_back(model(c, disp, mask));
    for (int c = 0; c < 50; c++) begin
      tick();
      obs_w = {bus.frame_tick, bus.digit_sel, bus.seg_out};
      exp_w = exp_q.pop_front();
      n_checks++;
      if (obs_w !== exp_w) $display("FAIL post_rst c=%0d got=%h exp=%h", c, obs_w, exp_w);
      else n_pass++;
    end
    stop_scan();
  endtask

  // Random patterns and mask, with both changed mid-frame.
  task automatic test_random();
    logic [5:0][6:0] d2;
    logic [5:0]      m2;
    int              chg;
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < ND; i++) disp[i] = 7'($urandom_range(0, 127));
      mask = 6'($urandom_range(0, 63));
      drive_inputs();
      d2 = disp;
      d2[$urandom_range(0, ND - 1)] = 7'($urandom_range(0, 127));
      m2 = 6'($urandom_range(0, 63));
      chg = $urandom_range(1, 46);
      for (int c = 0; c < 48; c++) exp_q.push_back(model(c, disp, mask));
      for (int c = 48; c < 96; c++) exp_q.push_back(model(c, d2, m2));
      bus.enable = 1'b1;
      for (int c = 0; c < 96; c++) begin
        tick();
        obs_w = {bus.frame_tick, bus.digit_sel, bus.seg_out};
        exp_w = exp_q.pop_front();
        n_checks++;
        if (obs_w !== exp_w) $display("FAIL random it=%0d c=%0d got=%h exp=%h", it, c, obs_w, exp_w);
        else n_pass++;
        if (c == chg) begin
          disp = d2;
          mask = m2;
          drive_inputs();
        end
      end
      stop_scan();
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_scan_order();
    test_snapshot();
    test_mask();
    test_enable_drop();
    test_mid_show_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
Time-multiplexed driver for the board's six-digit common-anode 7-segment display. It consumes the six per-digit segment patterns produced by the arithmetic/display blocks, drives one digit at a time onto a shared segment bus, and rotates through the digits at a fixed refresh rate. A short blanking gap between digits suppresses ghosting. The input patterns are snapshotted once per frame so every frame is glitch-free.

Parameters:
NUM_DIGITS, 6, number of digits scanned. The ports are sized for 6; the value is fixed at 6.
REFRESH_DIV, 50000, clock cycles per digit slot (blank plus show). Must be greater than BLANK_CYCLES.
BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off. Must be at least 1.
SEG_OFF, 7'b1111111, segment-bus value driven while blanked (segments are active-low).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
enable  input  1  scanning enabled when 1.
display0..display5  input  7 each  segment patterns for digits 0..5, in the same encoding as the 7-segment decoder outputs; passed through unmodified.
blank_mask  input  6  bit i = 1 keeps digit i dark during its slot.
seg_out  output  7  shared segment bus.
digit_sel  output  6  anode selects, active-low, at most one bit low at any time.
frame_tick  output  1  one-cycle pulse marking the end of a full frame.

Behaviour:
- Reset is asynchronous and active-low. While rst_n is 0, without waiting for a clock edge: seg_out = SEG_OFF, digit_sel = 6'b111111, frame_tick = 0, state = IDLE, idx = 0, cnt = 0, all snapshot registers cleared to SEG_OFF, snapshot mask cleared to 0.
- All outputs are registered and are a Moore function of the state registers.
- State IDLE: outputs off. On a rising edge with enable = 1, go to BLANK with idx = 0 and cnt = 0, and on that same edge load the snapshots of display0..5 and blank_mask.
- State BLANK:
  - digit_sel = all 1, seg_out = SEG_OFF.
  - cnt increments each cycle.
  - When cnt reaches BLANK_CYCLES-1, go to SHOW.
- State SHOW:
  - If snapshot mask bit idx is 0: digit_sel[idx] = 0 and seg_out = snapshot[idx].
  - If snapshot mask bit idx is 1: outputs stay off, but the slot time is still consumed.
  - When cnt reaches REFRESH_DIV-1: cnt returns to 0 and idx advances, wrapping from NUM_DIGITS-1 to 0. Go to BLANK.
  - When that wrap occurs (leaving digit NUM_DIGITS-1), reload the snapshots on the same edge.
- Slot timing: each slot lasts exactly REFRESH_DIV cycles, of which BLANK_CYCLES are blank and REFRESH_DIV-BLANK_CYCLES are show. A frame lasts NUM_DIGITS*REFRESH_DIV cycles.
- frame_tick is 1 only during the final SHOW cycle of digit NUM_DIGITS-1, every frame, regardless of blank_mask.
- Input changes in mid-frame do not affect the current frame. They are shown from the next frame onward.
- enable = 0 sampled at any edge, in any state: on that edge go to IDLE, outputs off, idx = 0, cnt = 0, frame_tick = 0.
- Re-asserting enable always restarts at digit 0 in BLANK with a fresh snapshot. There is no resume mid-frame.
- Reset during SHOW turns the anode off immediately, without waiting for a clock edge.
- Invariant: digit_sel never has more than one bit low. Verification checks this every cycle.

Test Plan:
All cases use REFRESH_DIV=8, BLANK_CYCLES=2, NUM_DIGITS=6. Cycle 0 is the first edge with enable=1 after reset.
1. Reset: hold rst_n=0 with no clock -> seg_out=7'h7F, digit_sel=6'b111111, frame_tick=0 immediately. Release rst_n with enable=0 -> outputs stay off.
2. Scan order: display0..5 = 7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12; blank_mask=0.
   - Cycles 0-1: blank.
   - Cycles 2-7: digit_sel=6'b111110, seg_out=7'h40.
   - Cycles 8-9: blank.
   - Cycles 10-15: digit_sel=6'b111101, seg_out=7'h79.
   - Pattern continues through digit 5 at cycles 42-47.
   - frame_tick=1 only in cycle 47.
   - Cycle 48: blank for digit 0.
3. Snapshot: change display3 from 7'h30 to 7'h00 at cycle 20 -> cycles 26-31 still show 7'h30. Cycles 74-79 show 7'h00.
4. Mask: blank_mask=6'b000100 -> cycles 18-23 have digit_sel=6'b111111 and seg_out=7'h7F. Digits 3..5 keep their original slot times. frame_tick is still at cycle 47.
5. Enable drop: enable=0 in cycle 13 -> from the next cycle, outputs off and frame_tick never fires. Re-assert enable -> 2 blank cycles, then digit 0 shows the current display0.
6. Mid-show reset: assert rst_n=0 at cycle 4, between edges -> digit_sel goes to 6'b111111 immediately. After release with enable=1, the sequence restarts exactly as in test 2.
